// File: rtl/if_id_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg_if
//   Bundles the fetch-side (f_*) and decode-side (D_*) signals of the IF->ID
//   pipeline register.
//
//   Modports:
//     master : the surrounding pipeline. Drives the fetch fields, f_valid,
//              D_stall and D_flush. Observes f_ready and the D_* outputs.
//     slave  : the pipeline register itself. Mirror image of master.
//
//   Signals:
//     f_valid / f_ready                          fetch handshake
//     f_op, f_func, f_rs, f_rt, f_rd, f_valC, f_pc  fetch fields
//     D_stall, D_flush                           decode-stage controls
//     D_valid, D_op, D_func, D_rs, D_rt, D_rd, D_valC, D_pc
//                                                registered decode fields
// -----------------------------------------------------------------------------
interface if_id_pipe_reg_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned REG_W  = 5
) ();

   // Fetch side
   logic              f_valid;
   logic              f_ready;
   logic [5:0]        f_op;
   logic [5:0]        f_func;
   logic [REG_W-1:0]  f_rs;
   logic [REG_W-1:0]  f_rt;
   logic [REG_W-1:0]  f_rd;
   logic [DATA_W-1:0] f_valC;
   logic [PC_W-1:0]   f_pc;

   // Decode side
   logic              D_stall;
   logic              D_flush;
   logic              D_valid;
   logic [5:0]        D_op;
   logic [5:0]        D_func;
   logic [REG_W-1:0]  D_rs;
   logic [REG_W-1:0]  D_rt;
   logic [REG_W-1:0]  D_rd;
   logic [DATA_W-1:0] D_valC;
   logic [PC_W-1:0]   D_pc;

   modport master (
      output f_valid, f_op, f_func, f_rs, f_rt, f_rd, f_valC, f_pc,
      output D_stall, D_flush,
      input  f_ready,
      input  D_valid, D_op, D_func, D_rs, D_rt, D_rd, D_valC, D_pc
   );

   modport slave (
      input  f_valid, f_op, f_func, f_rs, f_rt, f_rd, f_valC, f_pc,
      input  D_stall, D_flush,
      output f_ready,
      output D_valid, D_op, D_func, D_rs, D_rt, D_rd, D_valC, D_pc
   );

endinterface

// File: rtl/if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg
//   Parametrised IF->ID pipeline register with flush (bubble insert) and a
//   1-entry skid buffer. f_ready comes straight from a flop, so a decode stall
//   never propagates combinationally back into fetch.
//
//   Parameters:
//     DATA_W  width of the constant field valC
//     PC_W    width of the PC field
//     REG_W   register-specifier width (rs/rt/rd)
//     CNT_W   perf counter width (exists only when IF_ID_PERF_EN is defined)
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous, active-high reset
//     bus        if_id_pipe_reg_if.slave: fetch handshake + fields in,
//                decode controls in, registered decode fields out
//     stall_cnt  (IF_ID_PERF_EN) cycles a live instruction was held by D_stall
//     flush_cnt  (IF_ID_PERF_EN) flushes that squashed at least one instruction
//
//   Configuration macro:
//     IF_ID_PERF_EN  adds the saturating stall/flush perf counters and CNT_W.
//                    Undefined by default: no counter ports or logic.
//
//   All-zero fields are the NOP encoding, so every empty slot reads as zero.
// -----------------------------------------------------------------------------
module if_id_pipe_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned PC_W   = 32,
`ifdef IF_ID_PERF_EN
   parameter int unsigned CNT_W  = 16,
`endif
   parameter int unsigned REG_W  = 5
) (
   input  logic                clk,
   input  logic                rst,
`ifdef IF_ID_PERF_EN
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    flush_cnt,
`endif
   if_id_pipe_reg_if.slave     bus
);

   // Packed layout of one instruction slot: {op, func, rs, rt, rd, valC, pc}
   localparam int unsigned FW = 12 + 3 * REG_W + DATA_W + PC_W;

   logic [FW-1:0] in_word;

   // Main register (M), visible on D_*
   logic          m_valid_q, m_valid_d;
   logic [FW-1:0] m_q, m_d;

   // Skid entry, catches the transfer accepted while M is held
   logic          skid_valid_q, skid_valid_d;
   logic [FW-1:0] skid_q, skid_d;

   logic accept;
   logic m_load;

   assign in_word = {bus.f_op, bus.f_func, bus.f_rs, bus.f_rt, bus.f_rd,
                     bus.f_valC, bus.f_pc};

   // f_ready is the inverse of a flop: full skid is the only back-pressure
   assign bus.f_ready = ~skid_valid_q;

   assign accept = bus.f_valid & ~skid_valid_q;

   // A stall against an empty M is meaningless, so M keeps loading
   assign m_load = ~bus.D_stall | ~m_valid_q;

   always_comb begin
      m_valid_d    = m_valid_q;
      m_d          = m_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;

      if (bus.D_flush) begin
         // Squash everything, including this cycle's input
         m_valid_d    = 1'b0;
         m_d          = '0;
         skid_valid_d = 1'b0;
         skid_d       = '0;
      end else if (m_load) begin
         if (skid_valid_q) begin
            // Drain the older skid entry first to keep program order
            m_valid_d    = 1'b1;
            m_d          = skid_q;
            skid_valid_d = accept;
            skid_d       = accept ? in_word : '0;
         end else if (accept) begin
            m_valid_d = 1'b1;
            m_d       = in_word;
         end else begin
            m_valid_d = 1'b0;
            m_d       = '0;
         end
      end else if (accept) begin
         // M held: park the transfer in the skid entry
         skid_valid_d = 1'b1;
         skid_d       = in_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid_q    <= 1'b0;
         m_q          <= '0;
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
      end else begin
         m_valid_q    <= m_valid_d;
         m_q          <= m_d;
         skid_valid_q <= skid_valid_d;
         skid_q       <= skid_d;
      end
   end

   assign bus.D_valid = m_valid_q;
   assign {bus.D_op, bus.D_func, bus.D_rs, bus.D_rt, bus.D_rd,
           bus.D_valC, bus.D_pc} = m_q;

`ifdef IF_ID_PERF_EN
   logic stall_inc;
   logic flush_inc;

   assign stall_inc = bus.D_stall & m_valid_q & ~bus.D_flush;
   assign flush_inc = bus.D_flush & (m_valid_q | skid_valid_q);

   // Both counters saturate at all-ones rather than wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_inc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (flush_inc && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: directed cases plus a randomised
// phase, all outputs checked against a scoreboard queue of accepted words.
module tb_if_id_pipe_reg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned PC_W   = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned FW     = 12 + 3 * REG_W + DATA_W + PC_W;

   logic clk;
   logic rst;

   int n_checks = 0;
   int n_errors = 0;

   logic [FW-1:0] sb_q[$];

   if_id_pipe_reg_if #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W)) bus ();

`ifdef IF_ID_PERF_EN
   logic [15:0] stall_cnt, flush_cnt;
   logic [1:0]  stall_cnt2, flush_cnt2;
   logic [15:0] exp_stall, exp_flush;
   logic [1:0]  exp_stall2;

   if_id_pipe_reg_if #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W)) bus2 ();

   assign bus2.f_valid = bus.f_valid;
   assign bus2.f_op    = bus.f_op;
   assign bus2.f_func  = bus.f_func;
   assign bus2.f_rs    = bus.f_rs;
   assign bus2.f_rt    = bus.f_rt;
   assign bus2.f_rd    = bus.f_rd;
   assign bus2.f_valC  = bus.f_valC;
   assign bus2.f_pc    = bus.f_pc;
   assign bus2.D_stall = bus.D_stall;
   assign bus2.D_flush = bus.D_flush;

   if_id_pipe_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W), .CNT_W(16)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt),
      .bus       (bus)
   );

   if_id_pipe_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W), .CNT_W(2)) u_dut_sat (
      .clk       (clk),
      .rst       (rst),
      .stall_cnt (stall_cnt2),
      .flush_cnt (flush_cnt2),
      .bus       (bus2)
   );
`else
   if_id_pipe_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_in(input logic v, input logic [5:0] op, input logic [5:0] func,
                           input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                           input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] valc,
                           input logic [PC_W-1:0] pc);
      bus.f_valid = v;
      bus.f_op    = op;
      bus.f_func  = func;
      bus.f_rs    = rs;
      bus.f_rt    = rt;
      bus.f_rd    = rd;
      bus.f_valC  = valc;
      bus.f_pc    = pc;
   endtask

   task automatic drive_val(input logic [DATA_W-1:0] valc);
      drive_in(1'b1, 6'h23, 6'h05, 5'd1, 5'd2, 5'd3, valc, {valc[29:0], 2'b00});
   endtask

   task automatic drive_idle();
      drive_in(1'b0, '0, '0, '0, '0, '0, '0, '0);
   endtask

   function automatic logic [FW-1:0] d_word();
      return {bus.D_op, bus.D_func, bus.D_rs, bus.D_rt, bus.D_rd, bus.D_valC, bus.D_pc};
   endfunction

   // Scoreboard monitor: queue holds accepted-but-unconsumed words, oldest first.
   // Queue depth 2 means M and skid are both occupied.
   always @(posedge clk) begin
      logic [FW-1:0] exp_w;
      logic          ready_exp;
      if (rst) begin
         sb_q.delete();
`ifdef IF_ID_PERF_EN
         exp_stall  = '0;
         exp_flush  = '0;
         exp_stall2 = '0;
`endif
      end else begin
         ready_exp = (sb_q.size() < 2);
         check_eq("sb_f_ready", bus.f_ready, ready_exp);
         check_eq("sb_d_valid", bus.D_valid, sb_q.size() != 0);
         if (sb_q.size() == 0) check_eq("sb_bubble_zero", d_word(), '0);
`ifdef IF_ID_PERF_EN
         check_eq("stall_cnt", stall_cnt, exp_stall);
         check_eq("flush_cnt", flush_cnt, exp_flush);
         check_eq("stall_cnt_sat", stall_cnt2, exp_stall2);
         if (bus.D_flush && sb_q.size() != 0 && exp_flush != 16'hffff) exp_flush++;
         if (!bus.D_flush && bus.D_stall && sb_q.size() != 0) begin
            if (exp_stall != 16'hffff) exp_stall++;
            if (exp_stall2 != 2'b11) exp_stall2++;
         end
`endif
         if (bus.D_flush) begin
            sb_q.delete();
         end else begin
            if (sb_q.size() != 0 && !bus.D_stall) begin
               exp_w = sb_q.pop_front();
               check_eq("sb_data", d_word(), exp_w);
            end
            if (bus.f_valid && ready_exp) begin
               sb_q.push_back({bus.f_op, bus.f_func, bus.f_rs, bus.f_rt, bus.f_rd,
                               bus.f_valC, bus.f_pc});
            end
         end
      end
   end

   initial begin
      rst         = 1'b1;
      bus.D_stall = 1'b0;
      bus.D_flush = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      check_eq("rst_d_valid", bus.D_valid, 1'b0);
      check_eq("rst_f_ready", bus.f_ready, 1'b1);
      check_eq("rst_fields", d_word(), '0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("idle_d_valid", bus.D_valid, 1'b0);

      // Pass-through
      drive_in(1'b1, 6'h00, 6'b100111, 5'd19, 5'd30, 5'd29, 32'd66, 32'h1000);
      @(negedge clk);
      check_eq("pt_valid", bus.D_valid, 1'b1);
      check_eq("pt_op", bus.D_op, 6'h00);
      check_eq("pt_func", bus.D_func, 6'b100111);
      check_eq("pt_rs", bus.D_rs, 5'd19);
      check_eq("pt_rt", bus.D_rt, 5'd30);
      check_eq("pt_rd", bus.D_rd, 5'd29);
      check_eq("pt_valc", bus.D_valC, 32'd66);
      check_eq("pt_pc", bus.D_pc, 32'h1000);

      // Stall + skid
      bus.D_stall = 1'b1;
      drive_val(32'd77);
      @(negedge clk);
      check_eq("stall_hold_valc", bus.D_valC, 32'd66);
      check_eq("stall_f_ready", bus.f_ready, 1'b0);
      drive_idle();
      @(negedge clk);
      check_eq("stall_hold2_valc", bus.D_valC, 32'd66);
      bus.D_stall = 1'b0;
      @(negedge clk);
      check_eq("drain_valc", bus.D_valC, 32'd77);
      check_eq("drain_f_ready", bus.f_ready, 1'b1);

      // Flush with full skid and stall
      drive_val(32'd88);
      @(negedge clk);
      check_eq("fl_m_valc", bus.D_valC, 32'd88);
      bus.D_stall = 1'b1;
      drive_val(32'd99);
      @(negedge clk);
      check_eq("fl_full_f_ready", bus.f_ready, 1'b0);
      check_eq("fl_full_valc", bus.D_valC, 32'd88);
      bus.D_flush = 1'b1;
      drive_val(32'd55);
      @(negedge clk);
      check_eq("fl_d_valid", bus.D_valid, 1'b0);
      check_eq("fl_valc", bus.D_valC, 32'd0);
      check_eq("fl_f_ready", bus.f_ready, 1'b1);
      bus.D_flush = 1'b0;
      bus.D_stall = 1'b0;
      drive_idle();
      repeat (2) begin
         @(negedge clk);
         check_eq("bubble_valid", bus.D_valid, 1'b0);
         check_eq("bubble_valc", bus.D_valC, 32'd0);
      end

      // Flush discards input even when ready
      bus.D_flush = 1'b1;
      drive_val(32'd123);
      @(negedge clk);
      check_eq("fl_discard_valid", bus.D_valid, 1'b0);
      bus.D_flush = 1'b0;
      drive_idle();
      @(negedge clk);

      // Back-to-back stream
      for (int i = 0; i < 5; i++) begin
         drive_val(32'd200 + i);
         @(negedge clk);
         check_eq("stream_valid", bus.D_valid, 1'b1);
         check_eq("stream_valc", bus.D_valC, 32'd200 + i);
      end
      drive_idle();
      @(negedge clk);
      check_eq("stream_end_valid", bus.D_valid, 1'b0);

`ifdef IF_ID_PERF_EN
      // 3 valid stall cycles then one flush
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive_val(32'd300);
      @(negedge clk);
      drive_idle();
      bus.D_stall = 1'b1;
      repeat (3) @(negedge clk);
      bus.D_stall = 1'b0;
      bus.D_flush = 1'b1;
      @(negedge clk);
      bus.D_flush = 1'b0;
      check_eq("perf_stall3", stall_cnt, 16'd3);
      check_eq("perf_flush1", flush_cnt, 16'd1);
      check_eq("perf_sat3", stall_cnt2, 2'd3);
      drive_val(32'd301);
      @(negedge clk);
      drive_idle();
      bus.D_stall = 1'b1;
      repeat (5) @(negedge clk);
      bus.D_stall = 1'b0;
      check_eq("perf_sat_hold", stall_cnt2, 2'd3);
      check_eq("perf_stall8", stall_cnt, 16'd8);
      @(negedge clk);
`endif

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         drive_in($urandom_range(0, 3) != 0, 6'($urandom), 6'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom), $urandom, $urandom);
         bus.D_stall = ($urandom_range(0, 9) < 3);
         bus.D_flush = ($urandom_range(0, 19) == 0);
         @(negedge clk);
      end
      bus.D_stall = 1'b0;
      bus.D_flush = 1'b0;
      drive_idle();
      repeat (3) @(negedge clk);

      // Mid-cycle asynchronous reset with M and skid both full
      bus.D_stall = 1'b1;
      drive_val(32'd400);
      @(negedge clk);
      drive_val(32'd401);
      @(negedge clk);
      check_eq("pre_rst_f_ready", bus.f_ready, 1'b0);
      drive_idle();
      #2 rst = 1'b1;
      #1;
      check_eq("async_rst_valid", bus.D_valid, 1'b0);
      check_eq("async_rst_f_ready", bus.f_ready, 1'b1);
      check_eq("async_rst_fields", d_word(), '0);
`ifdef IF_ID_PERF_EN
      check_eq("async_rst_stall_cnt", stall_cnt, 16'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      bus.D_stall = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("post_rst_valid", bus.D_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
